// File: rtl/final_soc_pkg.sv
// Shared definitions for the final_soc PIO blocks: register offsets and
// bit positions of the keycode-input register map.
package final_soc_pkg;

  typedef enum logic [1:0] {
    KEYIN_DATA   = 2'd0,
    KEYIN_STATUS = 2'd1,
    KEYIN_IRQEN  = 2'd2,
    KEYIN_CTRL   = 2'd3
  } keyin_reg_e;

  localparam int DATA_VALID_BIT = 8;
  localparam int STAT_FULL_BIT  = 30;
  localparam int STAT_OVF_BIT   = 31;

endpackage

// File: rtl/keycode_fifo.sv
// Small synchronous FIFO holding keycodes; head is presented combinationally
// and flush clears the occupancy without touching the storage.
module keycode_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  // A push is only honoured when there is room; a pop only when data exists.
  assign push_ok_s = push & ~full & ~flush;
  assign pop_ok_s  = pop & ~empty & ~flush;

  // Pointer and occupancy tracking; flush takes priority over push/pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Keycode storage, cleared on reset so the head never reads as X.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == {(AW+1){1'b0}});

endmodule

// File: rtl/final_soc_keycode_in.sv
// Avalon-MM PIO that buffers keyboard keycodes for the CPU, with a level IRQ
// while keys are pending and a sticky overflow flag.
module final_soc_keycode_in
  import final_soc_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] key_data,
  input  logic              key_valid,
  output logic              key_ready,
  output logic              irq
);

  localparam int AW = $clog2(DEPTH);

  keyin_reg_e        reg_s;
  logic              rd_s;
  logic              wr_s;
  logic              push_s;
  logic              pop_s;
  logic              flush_s;
  logic              ovf_set_s;
  logic              ovf_clr_s;
  logic [DATA_W-1:0] head_s;
  logic [AW:0]       count_s;
  logic              full_s;
  logic              empty_s;
  logic              overflow_r;
  logic              irq_en_r;
  logic [31:0]       readdata_r;
  logic [31:0]       rd_word_s;
  logic              unused_wdata_s;

  assign reg_s   = keyin_reg_e'(address);
  assign rd_s    = chipselect & ~read_n;
  assign wr_s    = chipselect & ~write_n;
  assign pop_s   = rd_s & (reg_s == KEYIN_DATA) & ~empty_s;
  assign flush_s = wr_s & (reg_s == KEYIN_CTRL) & writedata[0];
  assign push_s  = key_valid & ~full_s;

  // A key offered while full is lost even if a pop frees a slot this cycle.
  assign ovf_set_s = key_valid & full_s;
  assign ovf_clr_s = wr_s & (reg_s == KEYIN_STATUS) & writedata[STAT_OVF_BIT];

  assign unused_wdata_s = ^writedata[30:1];

  keycode_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_s),
    .pop     (pop_s),
    .flush   (flush_s),
    .din     (key_data),
    .dout    (head_s),
    .count   (count_s),
    .full    (full_s),
    .empty   (empty_s)
  );

  // Read-word mux, built from the pre-edge FIFO state.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    case (reg_s)
      KEYIN_DATA: begin
        if (!empty_s) begin
          rd_word_s[DATA_W-1:0]     = head_s;
          rd_word_s[DATA_VALID_BIT] = 1'b1;
        end else begin
          rd_word_s = 32'h0000_0000;
        end
      end
      KEYIN_STATUS: begin
        rd_word_s[AW:0]          = count_s;
        rd_word_s[STAT_FULL_BIT] = full_s;
        rd_word_s[STAT_OVF_BIT]  = overflow_r;
      end
      KEYIN_IRQEN: rd_word_s[0] = irq_en_r;
      KEYIN_CTRL:  rd_word_s    = 32'h0000_0000;
      default:     rd_word_s    = 32'h0000_0000;
    endcase
  end

  // readdata updates only on a read strobe and otherwise holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_r <= 32'h0000_0000;
    end else if (rd_s) begin
      readdata_r <= rd_word_s;
    end
  end

  // Sticky overflow (set beats clear) and interrupt enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r <= 1'b0;
      irq_en_r   <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (ovf_clr_s) begin
        overflow_r <= 1'b0;
      end
      if (wr_s && (reg_s == KEYIN_IRQEN)) begin
        irq_en_r <= writedata[0];
      end
    end
  end

  assign readdata  = readdata_r;
  assign key_ready = ~full_s;
  assign irq       = irq_en_r & ~empty_s;

endmodule
